// File: rtl/mmu_pkg.sv
// mmu_pkg: shared FSM encoding, default widths and job-length helper for the NxN feeder
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int DEF_N  = 2;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 16;

    // Cycles from the first operand slot to the last SETTLE cycle, inclusive
    function automatic int job_len(input int n);
        return 3 * n - 1;
    endfunction

endpackage

// File: rtl/mmu_sat.sv
// mmu_sat: CW-bit signed result to DW-bit host word; saturates when MMU_FEEDER_SATURATE_EN is defined, else truncates
module mmu_sat #(
    parameter int CW = 16,
    parameter int DW = 8
) (
    input  logic [CW-1:0] i_c,
    output logic [DW-1:0] o_d
);

`ifdef MMU_FEEDER_SATURATE_EN
    logic w_fits;

    // The value fits when every bit from DW-1 upward matches the sign bit
    assign w_fits = (i_c[CW-1:DW-1] == {(CW-DW+1){i_c[CW-1]}});
    assign o_d    = w_fits ? i_c[DW-1:0] : {i_c[CW-1], {(DW-1){~i_c[CW-1]}}};
`else
    logic w_unused;

    assign w_unused = ^i_c;
    assign o_d      = i_c[DW-1:0];
`endif

endmodule

// File: rtl/mmu_feeder_n.sv
// mmu_feeder_n: skews latched W/I operands into an NxN systolic array, then drains N*N results over valid/ready (MMU_FEEDER_SATURATE_EN selects saturation in mmu_sat)
module mmu_feeder_n
    import mmu_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*N*DW-1:0] weight_flat,
    input  logic [N*N*DW-1:0] input_flat,
    input  logic [N*N*CW-1:0] c_flat,
    output logic              clear,
    output logic [N*DW-1:0]   a_data,
    output logic [N*DW-1:0]   b_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     host_outdata,
    output logic              out_last,
    output logic              done
);

    localparam int TW       = $clog2(3 * N);
    localparam int IW       = $clog2(N * N);
    localparam int FEED_END = 2 * N - 2;
    localparam int LAST_T   = job_len(N) - 1;
    localparam int LAST_IDX = N * N - 1;

    state_t              r_state, w_state_nxt;
    logic [TW-1:0]       r_t;
    logic [IW-1:0]       r_idx;
    logic [N*N*DW-1:0]   r_w, r_i, w_wsrc, w_isrc;
    logic [N*N*CW-1:0]   r_buf;
    logic [N*DW-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
    logic                r_clear, r_valid, r_done;
    logic                w_accept, w_last;
    int                  w_tn;
    logic [CW-1:0]       w_res;
    logic [DW-1:0]       w_conv;

    assign w_accept = r_valid && out_ready;
    assign w_last   = (r_idx == IW'(LAST_IDX));
    // On the start edge the operand slot comes straight from the host buses
    assign w_wsrc   = (r_state == IDLE) ? weight_flat : r_w;
    assign w_isrc   = (r_state == IDLE) ? input_flat : r_i;
    assign w_res    = r_buf[int'(r_idx)*CW +: CW];

    mmu_sat #(.CW(CW), .DW(DW)) u_sat (
        .i_c (w_res),
        .o_d (w_conv)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state: FEED for 2N-1 cycles, SETTLE up to cycle 3N-2, DRAIN until the last result is taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? FEED : IDLE;
            FEED:    w_state_nxt = (r_t == TW'(FEED_END)) ? SETTLE : FEED;
            SETTLE:  w_state_nxt = (r_t == TW'(LAST_T)) ? DRAIN : SETTLE;
            DRAIN:   w_state_nxt = (w_accept && w_last) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Skewed operand slot for the next cycle; lanes outside their diagonal window read 0
    always_comb begin
        w_a_nxt = '0;
        w_b_nxt = '0;
        w_tn    = (r_state == IDLE) ? 0 : int'(r_t) + 1;
        if (w_state_nxt == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (w_tn >= i && w_tn - i < N) begin
                    w_a_nxt[i*DW +: DW] = w_wsrc[(i*N + w_tn - i)*DW +: DW];
                    w_b_nxt[i*DW +: DW] = w_isrc[((w_tn - i)*N + i)*DW +: DW];
                end
            end
        end
    end

    // Datapath: operand latch, job counter, result snapshot and drain handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w     <= '0;
            r_i     <= '0;
            r_buf   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_t     <= '0;
            r_idx   <= '0;
            r_clear <= 1'b1;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_a    <= w_a_nxt;
            r_b    <= w_b_nxt;
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_w     <= weight_flat;
                r_i     <= input_flat;
                r_clear <= 1'b0;
                r_t     <= '0;
            end
            if (r_state == FEED || r_state == SETTLE)
                r_t <= r_t + 1'b1;
            if (r_state == SETTLE && r_t == TW'(LAST_T)) begin
                r_buf   <= c_flat;
                r_idx   <= '0;
                r_valid <= 1'b1;
            end
            if (w_accept) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                    r_clear <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign clear        = r_clear;
    assign a_data       = r_a;
    assign b_data       = r_b;
    assign busy         = (r_state != IDLE);
    assign out_valid    = r_valid;
    assign host_outdata = r_valid ? w_conv : '0;
    assign out_last     = r_valid && w_last;
    assign done         = r_done;

endmodule

// File: tb/tb_mmu_feeder_n.sv
// tb_mmu_feeder_n: directed checks of skew, drain, backpressure, conversion and reset for N=2 and N=4
module tb_mmu_feeder_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic        start2 = 1'b0, ready2 = 1'b0;
    logic [31:0] w2, i2;
    logic [63:0] c2, c2_model;
    logic        clear2, busy2, valid2, last2, done2;
    logic [15:0] a2, b2;
    logic [7:0]  host2;

    logic         start4 = 1'b0, ready4 = 1'b0;
    logic [127:0] w4, i4;
    logic [255:0] c4;
    logic         clear4, busy4, valid4, last4, done4;
    logic [31:0]  a4, b4;
    logic [7:0]   host4;

    mmu_feeder_n #(.N(2), .DW(8), .CW(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .weight_flat(w2), .input_flat(i2),
        .c_flat(c2), .clear(clear2), .a_data(a2), .b_data(b2), .busy(busy2),
        .out_valid(valid2), .out_ready(ready2), .host_outdata(host2), .out_last(last2), .done(done2)
    );

    mmu_feeder_n #(.N(4), .DW(8), .CW(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .weight_flat(w4), .input_flat(i4),
        .c_flat(c4), .clear(clear4), .a_data(a4), .b_data(b4), .busy(busy4),
        .out_valid(valid4), .out_ready(ready4), .host_outdata(host4), .out_last(last4), .done(done4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] conv(input logic signed [15:0] c);
`ifdef MMU_FEEDER_SATURATE_EN
        return (c > 16'sd127) ? 8'h7f : (c < -16'sd128) ? 8'h80 : c[7:0];
`else
        return c[7:0];
`endif
    endfunction

    // Caller is in cycle 0 of an N=2 job; streams four results with out_ready held high
    task automatic drain2(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        logic [31:0] ev;
        ev = {e3, e2, e1, e0};
        ready2 = 1'b1;
        repeat (4) tick;
        check({tag, "_pre_valid"}, 64'(valid2), 64'd0);
        tick;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 64'(valid2), 64'd1);
            check($sformatf("%s_data%0d", tag, k), 64'(host2), 64'(ev[k*8 +: 8]));
            check($sformatf("%s_last%0d", tag, k), 64'(last2), 64'(k == 3));
            tick;
        end
        check({tag, "_done"}, 64'(done2), 64'd1);
        check({tag, "_busy_end"}, 64'(busy2), 64'd0);
        tick;
        check({tag, "_done_pulse"}, 64'(done2), 64'd0);
    endtask

    initial begin
        int s;
        logic [7:0] exp300, expm200;
        w2 = {8'd4, 8'd3, 8'd2, 8'd1};
        i2 = {8'd8, 8'd7, 8'd6, 8'd5};
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'(w2[(r*2+k)*8 +: 8]) * int'(i2[(k*2+c)*8 +: 8]);
                c2_model[(r*2+c)*16 +: 16] = 16'(s);
            end
        c2 = c2_model;
        for (int e = 0; e < 16; e++) begin
            w4[e*8 +: 8] = 8'(e + 1);
            i4[e*8 +: 8] = 8'(e + 1);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += int'(w4[(r*4+k)*8 +: 8]) * int'(i4[(k*4+c)*8 +: 8]);
                c4[(r*4+c)*16 +: 16] = 16'(s);
            end

        repeat (2) tick;
        check("rst_clear", 64'(clear2), 64'd1);
        check("rst_busy", 64'(busy2), 64'd0);
        check("rst_a", 64'(a2), 64'd0);
        check("rst_b", 64'(b2), 64'd0);
        check("rst_valid", 64'(valid2), 64'd0);
        check("rst_host", 64'(host2), 64'd0);
        check("rst_last", 64'(last2), 64'd0);
        check("rst_done", 64'(done2), 64'd0);
        rst_n = 1'b1;
        tick;

        // Job 1: skew, snapshot isolation and backpressure
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("c0_a", 64'(a2), 64'h0001);
        check("c0_b", 64'(b2), 64'h0005);
        check("c0_clear", 64'(clear2), 64'd0);
        check("c0_busy", 64'(busy2), 64'd1);
        w2 = '1;
        i2 = '1;
        tick;
        check("c1_a", 64'(a2), 64'h0302);
        check("c1_b", 64'(b2), 64'h0607);
        tick;
        check("c2_a", 64'(a2), 64'h0400);
        check("c2_b", 64'(b2), 64'h0800);
        tick;
        check("c3_ab", 64'({a2, b2}), 64'd0);
        tick;
        check("c4_ab", 64'({a2, b2}), 64'd0);
        check("c4_valid", 64'(valid2), 64'd0);
        check("c4_clear", 64'(clear2), 64'd0);
        ready2 = 1'b1;
        tick;
        check("c5_valid", 64'(valid2), 64'd1);
        check("c5_data", 64'(host2), 64'd19);
        check("c5_last", 64'(last2), 64'd0);
        c2 = '0;
        tick;
        check("bp_data0", 64'(host2), 64'd22);
        ready2 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            check($sformatf("bp_hold%0d", k), 64'(host2), 64'd22);
            check($sformatf("bp_valid%0d", k), 64'(valid2), 64'd1);
        end
        ready2 = 1'b1;
        tick;
        check("bp_data2", 64'(host2), 64'd43);
        check("bp_last2", 64'(last2), 64'd0);
        tick;
        check("bp_data3", 64'(host2), 64'd50);
        check("bp_last3", 64'(last2), 64'd1);
        check("bp_clear3", 64'(clear2), 64'd0);
        tick;
        check("j1_done", 64'(done2), 64'd1);
        check("j1_valid_off", 64'(valid2), 64'd0);
        check("j1_clear", 64'(clear2), 64'd1);
        tick;
        check("j1_done_pulse", 64'(done2), 64'd0);

        // Reset mid-FEED, then a clean job
        w2 = {8'd4, 8'd3, 8'd2, 8'd1};
        i2 = {8'd8, 8'd7, 8'd6, 8'd5};
        c2 = c2_model;
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        check("mr_a", 64'(a2), 64'd0);
        check("mr_b", 64'(b2), 64'd0);
        check("mr_clear", 64'(clear2), 64'd1);
        check("mr_busy", 64'(busy2), 64'd0);
        check("mr_valid", 64'(valid2), 64'd0);
        check("mr_done", 64'(done2), 64'd0);
        tick;
        rst_n = 1'b1;
        tick;
        check("mr_idle", 64'(busy2), 64'd0);
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        check("mr_c0_a", 64'(a2), 64'h0001);
        drain2("rec", 8'd19, 8'd22, 8'd43, 8'd50);

        // Result conversion of out-of-range values
`ifdef MMU_FEEDER_SATURATE_EN
        exp300 = 8'h7f;
        expm200 = 8'h80;
`else
        exp300 = 8'h2c;
        expm200 = 8'h38;
`endif
        c2 = {16'd0, 16'd0, 16'hff38, 16'd300};
        start2 = 1'b1;
        tick;
        start2 = 1'b0;
        drain2("sat", exp300, expm200, 8'd0, 8'd0);

        // N=4: skew extent, latency and ignored start while busy
        ready4 = 1'b1;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            check($sformatf("n4_a3_t%0d", t), 64'(a4[31:24]), (t >= 3 && t <= 6) ? 64'(13 + t - 3) : 64'd0);
            check($sformatf("n4_b3_t%0d", t), 64'(b4[31:24]), (t >= 3 && t <= 6) ? 64'(4 * (t - 3) + 4) : 64'd0);
            check($sformatf("n4_valid_t%0d", t), 64'(valid4), 64'd0);
            start4 = (t == 8 || t == 9);
            tick;
        end
        start4 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("n4_valid%0d", k), 64'(valid4), 64'd1);
            check($sformatf("n4_data%0d", k), 64'(host4), 64'(conv(c4[k*16 +: 16])));
            check($sformatf("n4_last%0d", k), 64'(last4), 64'(k == 15));
            tick;
        end
        check("n4_done", 64'(done4), 64'd1);
        check("n4_busy_end", 64'(busy4), 64'd0);
        tick;
        check("n4_done_pulse", 64'(done4), 64'd0);
        check("n4_no_requeue", 64'(busy4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
